// File: rtl/md4_padder.sv
// md4_padder
// Byte-serial MD4 message padder and block formatter. Collects message
// bytes into a 512-bit block, appends 0x80, zero-fills and places the
// 64-bit little-endian bit length in words 14/15. Emits one block per
// out_valid/out_ready handshake, in the layout the MD4 round chain expects.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   byte stream handshake; in_data byte, in_last marks
//                       the final message byte (sampled on accept only)
//   out_valid/out_ready block handshake
//   out_block[511:0]    byte n at [8n+7:8n] (word k = bytes 4k..4k+3, LE)
//   out_final           block carries the length field (qualified by valid)
module md4_padder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         out_final
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_LEN  = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  logic [1:0]       state;
  logic [63:0][7:0] blk;       // byte-addressed view; flattens to out_block
  logic [5:0]       idx;
  logic [60:0]      cnt;
  logic             pend_pad;  // message ended exactly on a block boundary
  logic             len_only;  // 0x80 spilled past byte 55; next block is length only
  logic             final_q;

  // Both handshakes decode purely from registered state.
  assign in_ready  = (state == S_FILL);
  assign out_valid = (state == S_EMIT);
  assign out_block = blk;
  assign out_final = final_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FILL;
      blk      <= '0;
      idx      <= '0;
      cnt      <= '0;
      pend_pad <= 1'b0;
      len_only <= 1'b0;
      final_q  <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_valid) begin
            blk[idx] <= in_data;
            idx      <= idx + 6'd1;
            cnt      <= cnt + 61'd1;
            if (idx == 6'd63) begin
              // Full block goes out first; padding (if the message ended
              // here) starts a fresh block afterwards.
              state    <= S_EMIT;
              final_q  <= 1'b0;
              pend_pad <= in_last;
            end else if (in_last) begin
              state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          blk[idx] <= 8'h80;
          if (idx <= 6'd55) begin
            state <= S_LEN;
          end else begin
            // No room for the 8 length bytes in this block.
            state    <= S_EMIT;
            final_q  <= 1'b0;
            len_only <= 1'b1;
          end
        end
        S_LEN: begin
          // Bytes 56..63 = bit length, little-endian; wraps modulo 2^64.
          blk[63:56] <= {cnt, 3'b000};
          state      <= S_EMIT;
          final_q    <= 1'b1;
        end
        S_EMIT: begin
          if (out_ready) begin
            blk     <= '0;
            idx     <= '0;
            final_q <= 1'b0;
            if (final_q) begin
              cnt   <= '0;
              state <= S_FILL;
            end else if (pend_pad) begin
              pend_pad <= 1'b0;
              state    <= S_PAD;
            end else if (len_only) begin
              len_only <= 1'b0;
              state    <= S_LEN;
            end else begin
              state <= S_FILL;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_md4_padder.sv
// Self-checking bench for md4_padder: table of known vectors, directed
// latency/backpressure/reset sequences, and random messages checked
// against a byte-level MD4 padding model.
module tb_md4_padder;

  typedef logic [7:0]   byte_q_t[$];
  typedef logic [511:0] blk_q_t[$];
  typedef bit           fin_q_t[$];

  typedef struct {
    int          len;
    int          base;
    int          blk;
    int          word;
    logic [31:0] w;
    bit          fin;
    int          nblk;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_last;
  logic [7:0]   in_data;
  logic         out_valid, out_ready, out_final;
  logic [511:0] out_block;

  int total = 0;
  int bad   = 0;
  bit rand_mode = 1'b0;

  blk_q_t rx_blk;
  fin_q_t rx_fin;

  always #5 clk = ~clk;

  md4_padder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_final (out_final)
  );

  // A transfer happens on the posedge following a negedge that sees valid && ready.
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      rx_blk.push_back(out_block);
      rx_fin.push_back(out_final);
    end

  always @(posedge clk)
    if (rand_mode) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: pad the whole message as a byte list, then slice into blocks.
  task automatic model(input byte_q_t m, output blk_q_t blks, output fin_q_t fins);
    byte_q_t      p;
    logic [63:0]  bl;
    logic [511:0] b;
    int           nb;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    blks = {};
    fins = {};
    for (int k = 0; k < nb; k++) begin
      b = '0;
      for (int i = 0; i < 64; i++) b[8*i +: 8] = p[64*k + i];
      blks.push_back(b);
      fins.push_back(k == nb - 1);
    end
  endtask

  function automatic byte_q_t mk_msg(input int len, input int base);
    byte_q_t m;
    for (int i = 0; i < len; i++) m.push_back(8'(base + i));
    return m;
  endfunction

  task automatic send_msg(input byte_q_t m, input bit last, input bit gaps);
    for (int i = 0; i < m.size(); i++) begin
      int g;
      int w;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      in_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = m[i];
      in_last  = last && (i == m.size() - 1);
      w = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        w++;
        if (w > 500) begin
          total++;
          bad++;
          $display("FAIL send_timeout: byte %0d never accepted", i);
          in_valid = 1'b0;
          in_last  = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_blocks(input string name, input int n);
    int w;
    w = 0;
    while (rx_blk.size() < n && w < 2000) begin @(posedge clk); #1; w++; end
    repeat (3) begin @(posedge clk); #1; end
    chk({name, "_nblk"}, rx_blk.size(), n);
  endtask

  task automatic cmp_model(input string name, input byte_q_t m);
    blk_q_t eb;
    fin_q_t ef;
    model(m, eb, ef);
    for (int k = 0; k < eb.size(); k++)
      if (k < rx_blk.size()) begin
        chk($sformatf("%s_blk%0d", name, k), rx_blk[k], eb[k]);
        chk($sformatf("%s_fin%0d", name, k), rx_fin[k], ef[k]);
      end
  endtask

  task automatic clear_rx();
    rx_blk = {};
    rx_fin = {};
  endtask

  vec_t    tv[13];
  byte_q_t m;
  blk_q_t  eb;
  fin_q_t  ef;
  logic [511:0] cap_b;
  logic         cap_f;
  int n;

  initial begin
    tv[0]  = '{3,  'h61, 0, 0,  32'h80636261, 1, 1};
    tv[1]  = '{3,  'h61, 0, 14, 32'h00000018, 1, 1};
    tv[2]  = '{3,  'h61, 0, 15, 32'h00000000, 1, 1};
    tv[3]  = '{55, 0,    0, 13, 32'h80363534, 1, 1};
    tv[4]  = '{55, 0,    0, 14, 32'h000001B8, 1, 1};
    tv[5]  = '{56, 0,    0, 14, 32'h00000080, 0, 2};
    tv[6]  = '{56, 0,    0, 15, 32'h00000000, 0, 2};
    tv[7]  = '{56, 0,    1, 14, 32'h000001C0, 1, 2};
    tv[8]  = '{56, 0,    1, 0,  32'h00000000, 1, 2};
    tv[9]  = '{64, 0,    0, 0,  32'h03020100, 0, 2};
    tv[10] = '{64, 0,    0, 15, 32'h3F3E3D3C, 0, 2};
    tv[11] = '{64, 0,    1, 0,  32'h00000080, 1, 2};
    tv[12] = '{64, 0,    1, 14, 32'h00000200, 1, 2};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_final", out_final, 0);
    chk("rst_out_block", out_block, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Table-driven vectors.
    for (int t = 0; t < 13; t++) begin
      m = mk_msg(tv[t].len, tv[t].base);
      clear_rx();
      send_msg(m, 1'b1, 1'b0);
      wait_blocks($sformatf("tv%0d", t), tv[t].nblk);
      if (rx_blk.size() > tv[t].blk) begin
        chk($sformatf("tv%0d_word%0d", t, tv[t].word),
            rx_blk[tv[t].blk][32*tv[t].word +: 32], tv[t].w);
        chk($sformatf("tv%0d_final", t), rx_fin[tv[t].blk], tv[t].fin);
      end
      cmp_model($sformatf("tv%0d", t), m);
    end

    // abc latency: valid two edges after the last byte is accepted.
    m = mk_msg(3, 'h61);
    clear_rx();
    send_msg(m, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("abc_latency", n, 2);
    wait_blocks("abc_lat", 1);
    cmp_model("abc_lat", m);

    // 64 bytes: first block valid at the edge that takes byte 63.
    out_ready = 1'b0;
    m = mk_msg(64, 'h10);
    clear_rx();
    send_msg(m, 1'b1, 1'b0);
    chk("b64_valid_now", out_valid, 1);
    chk("b64_final0",    out_final, 0);
    chk("b64_in_ready",  in_ready,  0);
    out_ready = 1'b1;
    wait_blocks("b64", 2);
    cmp_model("b64", m);

    // Backpressure on abc, then an immediate second abc.
    out_ready = 1'b0;
    m = mk_msg(3, 'h61);
    clear_rx();
    send_msg(m, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_valid", out_valid, 1);
    cap_b = out_block;
    cap_f = out_final;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_blk%0d", c), out_block, cap_b);
      chk($sformatf("bp_hold_fin%0d", c), out_final, cap_f);
      chk($sformatf("bp_in_ready%0d", c), in_ready, 0);
      chk($sformatf("bp_valid%0d", c), out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_one_xfer",   rx_blk.size(), 1);
    chk("bp_valid_fall", out_valid, 0);
    chk("bp_in_ready",   in_ready, 1);
    send_msg(m, 1'b1, 1'b0);
    wait_blocks("bp", 2);
    if (rx_blk.size() == 2) chk("bp_same_block", rx_blk[1], rx_blk[0]);
    model(m, eb, ef);
    if (rx_blk.size() == 2) chk("bp_second_model", rx_blk[1], eb[0]);
    cmp_model("bp", m);

    // Reset mid-message, asserted between edges.
    clear_rx();
    send_msg(mk_msg(10, 'h41), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m = mk_msg(3, 'h61);
    send_msg(m, 1'b1, 1'b0);
    wait_blocks("after_rst", 1);
    if (rx_blk.size() > 0) chk("after_rst_len", rx_blk[0][32*14 +: 32], 32'h18);
    cmp_model("after_rst", m);

    // Random messages with input gaps and random backpressure.
    rand_mode = 1'b1;
    for (int r = 0; r < 20; r++) begin
      int len;
      m = {};
      len = $urandom_range(1, 140);
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      model(m, eb, ef);
      clear_rx();
      send_msg(m, 1'b1, 1'b1);
      wait_blocks($sformatf("rnd%0d", r), eb.size());
      cmp_model($sformatf("rnd%0d", r), m);
    end
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);
    #2 out_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
